// File: rtl/mips_dmem_responder.sv
// Word-addressed data-memory responder with programmable wait states and a one-cycle ready/err pulse.
// Optional build macro DMEM_STATS_EN adds saturating load/store success counters.
module mips_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err,
    output logic        busy
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] load_count,
    output logic [15:0] store_count
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_data;
    logic            lat_load, lat_store, lat_err;
    logic [31:0]     rd_q;
    logic [31:0]     ram [DEPTH_WORDS];
    logic            accept, req_err;
    logic            unused_addr;

    assign unused_addr = ^addr[31:AW+2];
    assign accept      = (state == IDLE) && (mem_read || mem_write);
    assign req_err     = (addr[1:0] != 2'b00) || (mem_read && mem_write);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_data  <= 32'd0;
            lat_load  <= 1'b0;
            lat_store <= 1'b0;
            lat_err   <= 1'b0;
            rd_q      <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_idx   <= addr[AW+1:2];
                lat_data  <= write_data;
                lat_load  <= mem_read && !req_err;
                lat_store <= mem_write && !req_err;
                lat_err   <= req_err;
            end
            if (state == RESP) begin
                if (lat_err)       rd_q <= 32'd0;
                else if (lat_load) rd_q <= ram[lat_idx];
            end
        end
    end

    // State is forced to IDLE asynchronously, so an aborted access can never reach this write.
    always_ff @(posedge clk) begin
        if (state == RESP && lat_store) ram[lat_idx] <= lat_data;
    end

    always_comb begin
        read_data = rd_q;
        if (state == RESP) begin
            if (lat_err)       read_data = 32'd0;
            else if (lat_load) read_data = ram[lat_idx];
        end
    end

    assign ready = (state == RESP);
    assign err   = (state == RESP) && lat_err;
    assign busy  = (state != IDLE);

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count  <= 16'd0;
            store_count <= 16'd0;
        end else if (state == RESP) begin
            if (lat_load && load_count != 16'hFFFF)   load_count  <= load_count + 16'd1;
            if (lat_store && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Table-driven bench for mips_dmem_responder: instance a uses two wait states, instance b uses none.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        a_mem_read = 1'b0, a_mem_write = 1'b0;
    logic [31:0] a_addr = '0, a_write_data = '0;
    logic [31:0] a_read_data;
    logic        a_ready, a_err, a_busy;

    logic        b_mem_read = 1'b0, b_mem_write = 1'b0;
    logic [31:0] b_addr = '0, b_write_data = '0;
    logic [31:0] b_read_data;
    logic        b_ready, b_err, b_busy;

`ifdef DMEM_STATS_EN
    logic [15:0] a_load_count, a_store_count, b_load_count, b_store_count;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd [2];
    int          exp_loads = 0;
    int          exp_stores = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .addr(a_addr), .write_data(a_write_data), .read_data(a_read_data),
        .ready(a_ready), .err(a_err), .busy(a_busy)
`ifdef DMEM_STATS_EN
        , .load_count(a_load_count), .store_count(a_store_count)
`endif
    );

    mips_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .addr(b_addr), .write_data(b_write_data), .read_data(b_read_data),
        .ready(b_ready), .err(b_err), .busy(b_busy)
`ifdef DMEM_STATS_EN
        , .load_count(b_load_count), .store_count(b_store_count)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] rdata_of(int sel);
        return (sel != 0) ? b_read_data : a_read_data;
    endfunction

    function automatic logic ready_of(int sel);
        return (sel != 0) ? b_ready : a_ready;
    endfunction

    function automatic logic err_of(int sel);
        return (sel != 0) ? b_err : a_err;
    endfunction

    function automatic logic busy_of(int sel);
        return (sel != 0) ? b_busy : a_busy;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one request at the current time and withdraws it just after the accepting edge.
    task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d);
        if (sel != 0) begin
            b_mem_read = rd; b_mem_write = wr; b_addr = a; b_write_data = d;
        end else begin
            a_mem_read = rd; a_mem_write = wr; a_addr = a; a_write_data = d;
        end
        @(posedge clk);
        #1;
        a_mem_read = 1'b0; a_mem_write = 1'b0;
        b_mem_read = 1'b0; b_mem_write = 1'b0;
    endtask

    task automatic doAccess(input int sel, input string name, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic exp_err, input logic [31:0] exp_data);
        int  n = 0;
        bit  seen = 1'b0;
        bit  busy_ok = 1'b1;
        int  exp_lat;
        exp_lat = (sel != 0) ? 1 : 3;
        applyStimulus(sel, rd, wr, a, d);
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (ready_of(sel)) begin
                seen = 1'b1;
                n = i;
            end else if (!busy_of(sel)) begin
                busy_ok = 1'b0;
            end
        end
        if (!seen) begin
            checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({name, " busy while waiting"}, 32'(busy_ok), 32'd1);
        checkOutput({name, " latency"}, 32'(n), 32'(exp_lat));
        checkOutput({name, " err"}, 32'(err_of(sel)), 32'(exp_err));
        if (exp_err)  last_rd[sel] = 32'd0;
        else if (rd)  last_rd[sel] = exp_data;
        if (sel == 0 && !exp_err) begin
            if (rd) exp_loads++;
            else    exp_stores++;
        end
        checkOutput({name, " read_data"}, rdata_of(sel), last_rd[sel]);
        @(negedge clk);
        checkOutput({name, " ready pulse end"}, 32'(ready_of(sel)), 32'd0);
        checkOutput({name, " idle after"}, 32'(busy_of(sel)), 32'd0);
        checkOutput({name, " read_data hold"}, rdata_of(sel), last_rd[sel]);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_000C, 32'h0000_0001, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_F7FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1357_9BDF, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1357_9BDF};
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset ready", 32'(a_ready), 32'd0);
        checkOutput("reset err", 32'(a_err), 32'd0);
        checkOutput("reset busy", 32'(a_busy), 32'd0);
        checkOutput("reset read_data", a_read_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a store mid-wait: the earlier value at 0x10 must survive.
        doAccess(0, "prestore 0x10", 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'h2222_2222);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort ready", 32'(a_ready), 32'd0);
        checkOutput("abort err", 32'(a_err), 32'd0);
        checkOutput("abort busy", 32'(a_busy), 32'd0);
        checkOutput("abort read_data", a_read_data, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        exp_loads = 0;
        exp_stores = 0;
        @(negedge clk);
        rst_n = 1'b1;
        doAccess(0, "load after abort", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1111_1111);

        for (int i = 0; i < 12; i++) begin
            doAccess(0, $sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a,
                     vecs[i].d, vecs[i].exp_err, vecs[i].exp_data);
        end

`ifdef DMEM_STATS_EN
        checkOutput("load_count", 32'(a_load_count), 32'(exp_loads));
        checkOutput("store_count", 32'(a_store_count), 32'(exp_stores));
`endif

        // Zero-wait instance: single-cycle latency, and a held strobe is accepted every second edge.
        doAccess(1, "b store 0x08", 1'b0, 1'b1, 32'h08, 32'h0BAD_F00D, 1'b0, 32'h0);
        doAccess(1, "b load 0x08", 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0BAD_F00D);
        b_mem_read = 1'b1;
        b_addr = 32'h08;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("b held ready %0d", i), 32'(b_ready), 32'((i % 2) == 0));
            if (b_ready) checkOutput($sformatf("b held data %0d", i), b_read_data, 32'h0BAD_F00D);
        end
        b_mem_read = 1'b0;
        @(negedge clk);
        checkOutput("b idle after held", 32'(b_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
